// File: rtl/nibble_add_seq_if.sv
// Host-side bundle for nibble_add_seq: start request, operands, and result/handshake.
// The master drives the request side and the slave (the sequencer) drives the results.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         cin;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, cin, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, cin, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_add_seq.sv
// Multi-precision adder that steps one nibble per cycle through a shared 4-bit ripple adder.
// Optional subtract support is enabled by defining NIBBLE_ADD_SEQ_SUB_EN; NIBBLES must be 2..8.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    nibble_add_seq_if.slave     bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  opA_q, opA_d;
    logic [W-1:0]  opB_q, opB_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  bEff;
    logic          cInit;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so the latched B is already inverted.
    assign bEff  = bus.sub ? ~bus.b : bus.b;
    assign cInit = bus.sub | bus.cin;
`else
    logic unusedSub;
    assign unusedSub = bus.sub;
    assign bEff      = bus.b;
    assign cInit     = bus.cin;
`endif

    logic [IW+1:0] bitBase;
    logic [3:0]    nibA;
    logic [3:0]    nibB;
    logic [3:0]    nibS;
    logic [4:0]    carryChain;

    assign bitBase       = {idx_q, 2'b00};
    assign nibA          = opA_q[bitBase +: 4];
    assign nibB          = opB_q[bitBase +: 4];
    assign carryChain[0] = carry_q;

    // Four 1-bit full-adder cells rippling the registered carry through the nibble.
    for (genvar k = 0; k < 4; k++) begin : g_fullAdder
        assign nibS[k]         = nibA[k] ^ nibB[k] ^ carryChain[k];
        assign carryChain[k+1] = (nibA[k] & nibB[k]) | (carryChain[k] & (nibA[k] ^ nibB[k]));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opA_d   = bus.a;
                    opB_d   = bEff;
                    carry_d = cInit;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[bitBase +: 4] = nibS;
                carry_d             = carryChain[4];
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = carryChain[4];
                    ovf_d   = (opA_q[W-1] == opB_q[W-1]) && (nibS[3] != opA_q[W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ena low freezes every register, so a stalled operation resumes exactly where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: directed vectors push expected results, a monitor
// pops and compares them on every done pulse.
module tb_nibble_add_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    exp_t expQ[$];
    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   acceptCyc  = 0;
    int   doneCount  = 0;
    int   doneBefore = 0;

    always #5 clk = ~clk;

    nibble_add_seq_if #(.NIBBLES(NIB)) bus ();

    nibble_add_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                e = expQ.pop_front();
                checkOutput("sum",  32'(bus.sum),  32'(e.sum));
                checkOutput("cout", 32'(bus.cout), 32'(e.cout));
                checkOutput("ovf",  32'(bus.ovf),  32'(e.ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acceptCyc = cyc;
        e = '{sum: es, cout: ec, ovf: eo};
        expQ.push_back(e);
        checkOutput("busy_at_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic waitDone(input int expEdges);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done in 40 cycles expected done");
        end else begin
            checkOutput("latency", 32'(cyc - acceptCyc), 32'(expEdges));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_sum",  32'(bus.sum),  32'd0);
        checkOutput("reset_cout", 32'(bus.cout), 32'd0);
        checkOutput("reset_ovf",  32'(bus.ovf),  32'd0);
        rst_n = 1'b1;

        $display("[TB] basic add and carry chain");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        waitDone(NIB);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitDone(NIB);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        waitDone(NIB);
        @(negedge clk);
        checkOutput("sum_hold_idle", 32'(bus.sum), 32'h8000);
        checkOutput("done_one_cycle", 32'(bus.done), 32'd0);

        $display("[TB] busy protection");
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.a     = 16'hAAAA;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(NIB);
        bus.a     = 16'h0003;
        bus.b     = 16'h0004;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("start_ignored_in_done", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acceptCyc = cyc;
        expQ.push_back('{sum: 16'h0007, cout: 1'b0, ovf: 1'b0});
        checkOutput("start_accepted_in_idle", 32'(bus.busy), 32'd1);
        waitDone(NIB);

        $display("[TB] ena freeze");
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("freeze_busy", 32'(bus.busy), 32'd1);
            checkOutput("freeze_sum",  32'(bus.sum),  32'h0000);
        end
        ena = 1'b1;
        waitDone(NIB + 3);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        waitDone(NIB);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_done", 32'(bus.done), 32'd0);
        checkOutput("rst_mid_sum",  32'(bus.sum),  32'd0);
        checkOutput("rst_mid_cout", 32'(bus.cout), 32'd0);
        checkOutput("rst_mid_ovf",  32'(bus.ovf),  32'd0);
        expQ.delete();
        doneBefore = doneCount;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(doneCount), 32'(doneBefore));
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        waitDone(NIB);

        $display("[TB] subtract request");
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        waitDone(NIB);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        waitDone(NIB);
`else
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        waitDone(NIB);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
        waitDone(NIB);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
